// File: rtl/motor_drive.sv
// BLDC six-step gate driver: hall-commutated phase selection, edge-aligned PWM on the
// high side, dead-time insertion between gate vectors, and stall/invalid-hall fault latch.
module motor_drive #(
  parameter int unsigned PWM_PERIOD   = 2500,
  parameter int unsigned DEAD_TIME    = 50,
  parameter int unsigned STALL_CYCLES = 25000000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        EN,
  input  logic        DIR,
  input  logic        BRAKE,
  input  logic [11:0] DUTY,
  input  logic        H1,
  input  logic        H2,
  input  logic        H3,
  output logic [2:0]  HS,
  output logic [2:0]  LS,
  output logic [1:0]  STATE,
  output logic        FAULT
);

  localparam int unsigned PW = ($clog2(PWM_PERIOD + 1) > 12) ? $clog2(PWM_PERIOD + 1) : 12;
  localparam int unsigned DW = (DEAD_TIME > 1) ? $clog2(DEAD_TIME + 1) : 1;
  localparam int unsigned SW = (STALL_CYCLES > 1) ? $clog2(STALL_CYCLES + 1) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_BRAKE = 2'b10,
    ST_FAULT = 2'b11
  } state_t;

  state_t state, state_nxt;

  logic [2:0]    h_meta, hall, hall_prev;
  logic          hall_edge, invalid, inv_q;
  logic [PW-1:0] pwm_cnt, duty_lat, duty_ext;
  logic          pwm_wrap, pwm_on;
  logic [SW-1:0] stall_cnt;
  logic          stall_run, stall_fault;
  logic [2:0]    tbl_hi, tbl_lo;
  logic [2:0]    tgt_hs, tgt_ls;
  logic [2:0]    pend_hs, pend_ls;
  logic [2:0]    vec_hs, vec_ls, vec_hs_nxt, vec_ls_nxt;
  logic [DW-1:0] dt_cnt, dt_nxt;

  // Hall synchronizers plus one extra stage for edge detection
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      h_meta    <= '0;
      hall      <= '0;
      hall_prev <= '0;
    end else begin
      h_meta    <= {H3, H2, H1};
      hall      <= h_meta;
      hall_prev <= hall;
    end
  end

  assign hall_edge = (hall != hall_prev);
  assign invalid   = (hall == 3'b000) || (hall == 3'b111);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) inv_q <= 1'b0;
    else     inv_q <= invalid && (state == ST_RUN);
  end

  assign pwm_wrap = (pwm_cnt == PW'(PWM_PERIOD - 1));
  assign duty_ext = PW'(DUTY);
  assign pwm_on   = (pwm_cnt < duty_lat);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pwm_cnt  <= '0;
      duty_lat <= '0;
    end else if (pwm_wrap) begin
      pwm_cnt  <= '0;
      duty_lat <= (duty_ext > PW'(PWM_PERIOD)) ? PW'(PWM_PERIOD) : duty_ext;
    end else begin
      pwm_cnt  <= pwm_cnt + PW'(1);
    end
  end

  // Stall timer only runs while actually driving current; the fault fires on the
  // cycle the count would reach STALL_CYCLES.
  assign stall_run   = (state == ST_RUN) && (duty_lat != '0) && !hall_edge;
  assign stall_fault = stall_run && (stall_cnt == SW'(STALL_CYCLES - 1));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)             stall_cnt <= '0;
    else if (!stall_run) stall_cnt <= '0;
    else if (!stall_fault) stall_cnt <= stall_cnt + SW'(1);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!EN) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  state_nxt = BRAKE ? ST_BRAKE : ST_RUN;
        ST_RUN: begin
          if (BRAKE)                                  state_nxt = ST_BRAKE;
          else if ((invalid && inv_q) || stall_fault) state_nxt = ST_FAULT;
        end
        ST_BRAKE: if (!BRAKE) state_nxt = ST_RUN;
        default:  state_nxt = ST_FAULT;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) FAULT <= 1'b0;
    else     FAULT <= (state_nxt == ST_FAULT);
  end

  assign STATE = state;

  // Forward commutation: one phase high, one phase low, third floating
  always_comb begin
    tbl_hi = '0;
    tbl_lo = '0;
    case (hall)
      3'b001: begin tbl_hi = 3'b001; tbl_lo = 3'b010; end
      3'b011: begin tbl_hi = 3'b001; tbl_lo = 3'b100; end
      3'b010: begin tbl_hi = 3'b010; tbl_lo = 3'b100; end
      3'b110: begin tbl_hi = 3'b010; tbl_lo = 3'b001; end
      3'b100: begin tbl_hi = 3'b100; tbl_lo = 3'b001; end
      3'b101: begin tbl_hi = 3'b100; tbl_lo = 3'b010; end
      default: begin tbl_hi = '0; tbl_lo = '0; end
    endcase
  end

  always_comb begin
    tgt_hs = '0;
    tgt_ls = '0;
    case (state)
      ST_RUN: begin
        tgt_hs = DIR ? tbl_hi : tbl_lo;
        tgt_ls = DIR ? tbl_lo : tbl_hi;
      end
      ST_BRAKE: tgt_ls = '1;
      default: begin
        tgt_hs = '0;
        tgt_ls = '0;
      end
    endcase
  end

  // pend_* tracks the latest target; any change blanks the gates and (re)starts the
  // dead timer, except a change to all-off which is safe to apply at once.
  always_comb begin
    vec_hs_nxt = vec_hs;
    vec_ls_nxt = vec_ls;
    dt_nxt     = dt_cnt;
    if ({tgt_hs, tgt_ls} != {pend_hs, pend_ls}) begin
      if (({tgt_hs, tgt_ls} == '0) || (DEAD_TIME == 0)) begin
        vec_hs_nxt = tgt_hs;
        vec_ls_nxt = tgt_ls;
        dt_nxt     = '0;
      end else begin
        vec_hs_nxt = '0;
        vec_ls_nxt = '0;
        dt_nxt     = DW'(DEAD_TIME);
      end
    end else if (dt_cnt != '0) begin
      dt_nxt = dt_cnt - DW'(1);
      if (dt_cnt == DW'(1)) begin
        vec_hs_nxt = pend_hs;
        vec_ls_nxt = pend_ls;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pend_hs <= '0;
      pend_ls <= '0;
      vec_hs  <= '0;
      vec_ls  <= '0;
      dt_cnt  <= '0;
      HS      <= '0;
    end else begin
      pend_hs <= tgt_hs;
      pend_ls <= tgt_ls;
      vec_hs  <= vec_hs_nxt;
      vec_ls  <= vec_ls_nxt;
      dt_cnt  <= dt_nxt;
      HS      <= vec_hs_nxt & {3{pwm_on}};
    end
  end

  assign LS = vec_ls;

endmodule

// File: doc/motor_drive.md
MOTOR_DRIVE -- requirements
Module: motor_drive

Interface
REQ-001 Parameter PWM_PERIOD, default 2500: PWM period in CLK cycles (20 kHz at 50 MHz).
REQ-002 Parameter DEAD_TIME, default 50: all-gates-off cycles inserted on every gate-vector change.
REQ-003 Parameter STALL_CYCLES, default 25000000: maximum cycles allowed in RUN without a hall edge.
REQ-004 CLK  in  1  system clock, 50 MHz; the block SHALL use one clock only.
REQ-005 RST  in  1  reset, asynchronous, active-high.
REQ-006 EN  in  1  drive enable; low SHALL force IDLE and clear a fault.
REQ-007 DIR  in  1  1 = forward, 0 = reverse.
REQ-008 BRAKE  in  1  1 = low-side brake request.
REQ-009 DUTY  in  12  high-side on-time per period in CLK cycles.
REQ-010 H1, H2, H3  in  1 each  hall inputs from the motor, asynchronous.
REQ-011 HS  out  3  high-side gates, bit0 = U, bit1 = V, bit2 = W.
REQ-012 LS  out  3  low-side gates, same bit order as HS.
REQ-013 STATE  out  2  drive state: 00 IDLE, 01 RUN, 10 BRAKE, 11 FAULT.
REQ-014 FAULT  out  1  latched fault flag.

Function
REQ-015 H1..H3 SHALL each pass a 2-FF synchronizer; hall code = {H3s,H2s,H1s}.
REQ-016 PWM counter SHALL count 0..PWM_PERIOD-1 and wrap to 0.
REQ-017 DUTY SHALL be latched only when the counter equals PWM_PERIOD-1; latched values above PWM_PERIOD SHALL be clamped to PWM_PERIOD.
REQ-018 pwm_on SHALL equal (counter < latched duty): duty 0 gives never on; duty PWM_PERIOD gives always on.
REQ-019 Forward table, code -> (high phase, low phase): 001 -> (U,V), 011 -> (U,W), 010 -> (V,W), 110 -> (V,U), 100 -> (W,U), 101 -> (W,V).
REQ-020 In reverse, the high phase and low phase of each table entry SHALL be swapped.
REQ-021 Codes 000 and 111 are invalid.
REQ-022 IDLE: target vector all zero; go to BRAKE if EN & BRAKE; go to RUN if EN & !BRAKE.
REQ-023 RUN: target = table entry; go to BRAKE on BRAKE; go to FAULT on an invalid code for 2 consecutive cycles or on stall (REQ-028).
REQ-024 BRAKE: target LS = 111, HS = 000; return to RUN when BRAKE deasserts.
REQ-025 FAULT: target all zero and FAULT = 1; the only exit is EN = 0, which goes to IDLE and clears FAULT.
REQ-026 EN = 0 SHALL force IDLE from any state; EN low has priority over BRAKE, and BRAKE has priority over RUN.
REQ-027 When the target vector changes, all gates SHALL be 0 for DEAD_TIME cycles before the new vector is applied.
  - A new change during the dead time SHALL restart the dead time.
  - A change to all-zero SHALL apply immediately, with no dead time.
REQ-028 Stall counter SHALL reset on any synchronized hall edge and hold 0 outside RUN or while latched duty = 0; reaching STALL_CYCLES SHALL cause FAULT.
REQ-029 Applied outputs: HS = vec_hs & {3{pwm_on}}; LS = vec_ls, unmodulated.
REQ-030 HS[i] & LS[i] SHALL never be 1 in the same cycle.
REQ-031 All outputs SHALL be registered.
REQ-032 Latency: a hall pin change at cycle n SHALL give gates all-off at n+3 and the new vector at n+3+DEAD_TIME.

Reset
REQ-033 While RST = 1, the block SHALL hold: HS = 000, LS = 000, STATE = 00, FAULT = 0, PWM counter 0, latched duty 0, stall counter 0, synchronizers 0, dead-time counter 0.
REQ-034 After RST falls, the block SHALL enter RUN or BRAKE no earlier than the first CLK edge.
REQ-035 RST asserted mid-PWM or mid-dead-time SHALL force all gates to 0 immediately, without waiting for a clock edge.

Verification
REQ-036 EN = 1, DIR = 1, DUTY = 1250, hall code 001 -> after the dead time, HS = 001 toggling 1250 on / 1250 off, LS = 010.
REQ-037 Hall code stepped 001 -> 011 -> LS goes 010 -> 000 for 50 cycles -> 100; HS never overlaps LS on the same phase.
REQ-038 DIR toggled 1 -> 0 with code 001 -> gates all-off for 50 cycles, then HS = 010 (V) PWM and LS = 001 (U).
REQ-039 Hall code 111 held for 2 cycles in RUN -> STATE = 11, FAULT = 1, gates 0; EN pulsed low -> STATE = 00, FAULT = 0.
REQ-040 BRAKE = 1 in RUN -> gates 0 for 50 cycles, then LS = 111 and HS = 000; BRAKE = 0 -> RUN vector after the dead time.
REQ-041 DUTY = 4095 -> HS constant-on (clamped); with STALL_CYCLES = 100 and no hall edge -> FAULT at cycle 100 of RUN.
